// File: rtl/squash_pkg.sv
// ----------------------------------------------------------------------------
// squash_pkg
// Shared types for the squash arbiter: ROB index, branch writeback payload,
// squash payload, the held-candidate record, FSM state encoding and the
// wrap-aware ROB age compare.
// No ports (package).
// ----------------------------------------------------------------------------
package squash_pkg;

    localparam int unsigned XLEN                = 64;
    localparam int unsigned MEMDEP_FOLDPC_WIDTH = 10;
    localparam int unsigned ROB_SIZE            = 64;
    localparam int unsigned ROB_IDX_W           = $clog2(ROB_SIZE);

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        robIdx_t         rob_idx;
        logic            has_mispred;
        logic            branch_taken;
        logic [XLEN-1:0] branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic                           dueToBranch;
        logic                           dueToViolation;
        logic                           branch_taken;
        logic [XLEN-1:0]                arch_pc;
        logic [MEMDEP_FOLDPC_WIDTH-1:0] ldpc;
        logic [MEMDEP_FOLDPC_WIDTH-1:0] stpc;
    } squashInfo_t;

    typedef struct packed {
        robIdx_t     rob_idx;
        squashInfo_t info;
    } squashCand_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SQUASH  = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StPending = ST_PENDING,
        StSquash  = ST_SQUASH
    } state_e;

    // The flag bit toggles on every idx wrap, so when flags differ the
    // numerically larger idx is the one allocated before the wrap.
    function automatic logic rob_older(robIdx_t a, robIdx_t b);
        return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/oldest_cand_select.sv
// ----------------------------------------------------------------------------
// oldest_cand_select
// Picks the oldest of the currently held entry and NUM_CAND incoming
// candidates.
//   cand_vld_i / cand_i : incoming candidates, lowest index wins age ties
//   held_vld_i / held_i : entry already held; it wins any tie
//   sel_vld_o           : some entry (held or incoming) is valid
//   sel_new_o           : the winner is an incoming candidate
//   sel_o               : the winning entry
// ----------------------------------------------------------------------------
module oldest_cand_select
    import squash_pkg::*;
#(
    parameter int unsigned NUM_CAND = 3
) (
    input  logic                       held_vld_i,
    input  squashCand_t                held_i,
    input  logic [NUM_CAND-1:0]        cand_vld_i,
    input  squashCand_t [NUM_CAND-1:0] cand_i,
    output logic                       sel_vld_o,
    output logic                       sel_new_o,
    output squashCand_t                sel_o
);

    logic        best_vld;
    logic        best_new;
    squashCand_t best;

    // Strict-older replacement in scan order gives the tie rules for free:
    // held beats equal incoming, lower port beats higher, violation is last.
    always_comb begin
        best_vld = held_vld_i;
        best_new = 1'b0;
        best     = held_i;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (cand_vld_i[i] && (!best_vld || rob_older(cand_i[i].rob_idx, best.rob_idx))) begin
                best_vld = 1'b1;
                best_new = 1'b1;
                best     = cand_i[i];
            end
        end
    end

    assign sel_vld_o = best_vld;
    assign sel_new_o = best_new;
    assign sel_o     = best;

endmodule

// File: rtl/squash_arbiter.sv
// ----------------------------------------------------------------------------
// squash_arbiter
// Collects branch mispredicts and LSU memory-order violations, holds the
// oldest one and emits a single squash pulse once it reaches retirement.
//   clk, rst                    : clock, synchronous active-high reset
//   i_bwb_vld / i_bwb_info      : branch writeback ports
//   i_viol_*                    : LSU violation report
//   i_rob_head_vld / _robidx    : completed ROB head (violation trigger)
//   i_retire_vld / _robidx      : retire lanes (branch trigger)
//   i_flush                     : trap flush, drops any held candidate
//   o_pending / o_pending_robidx: held candidate, index zero when none
//   o_squash_vld / o_squash_info: one-cycle squash pulse and payload
// ----------------------------------------------------------------------------
module squash_arbiter
    import squash_pkg::*;
#(
    parameter int unsigned BRU_NUM      = 2,
    parameter int unsigned COMMIT_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [BRU_NUM-1:0]                   i_bwb_vld,
    input  branchwbInfo_t [BRU_NUM-1:0]          i_bwb_info,
    input  logic                                 i_viol_vld,
    input  robIdx_t                              i_viol_robidx,
    input  logic [MEMDEP_FOLDPC_WIDTH-1:0]       i_viol_ldpc,
    input  logic [MEMDEP_FOLDPC_WIDTH-1:0]       i_viol_stpc,
    input  logic [XLEN-1:0]                      i_viol_pc,
    input  logic                                 i_rob_head_vld,
    input  robIdx_t                              i_rob_head_robidx,
    input  logic [COMMIT_WIDTH-1:0]              i_retire_vld,
    input  robIdx_t [COMMIT_WIDTH-1:0]           i_retire_robidx,
    input  logic                                 i_flush,
    output logic                                 o_pending,
    output robIdx_t                              o_pending_robidx,
    output logic                                 o_squash_vld,
    output squashInfo_t                          o_squash_info
);

    localparam int unsigned NumCand = BRU_NUM + 1;

    state_e      state_q, state_d;
    squashCand_t held_q, held_d;
    logic        pending_q, pending_d;
    robIdx_t     pending_robidx_q, pending_robidx_d;
    logic        squash_vld_q, squash_vld_d;
    squashInfo_t squash_info_q, squash_info_d;

    logic [NumCand-1:0]        cand_vld;
    squashCand_t [NumCand-1:0] cand;
    logic                      sel_vld;
    logic                      sel_new;
    squashCand_t               sel;
    logic                      held_vld;
    logic                      retire_hit;
    logic                      head_hit;
    logic                      trigger;

    // Branch ports first, violation in the last slot.
    always_comb begin
        cand_vld = '0;
        cand     = '0;
        for (int unsigned j = 0; j < BRU_NUM; j++) begin
            cand_vld[j]                  = i_bwb_vld[j] & i_bwb_info[j].has_mispred;
            cand[j].rob_idx              = i_bwb_info[j].rob_idx;
            cand[j].info.dueToBranch     = 1'b1;
            cand[j].info.branch_taken    = i_bwb_info[j].branch_taken;
            cand[j].info.arch_pc         = i_bwb_info[j].branch_npc;
        end
        cand_vld[BRU_NUM]                 = i_viol_vld;
        cand[BRU_NUM].rob_idx             = i_viol_robidx;
        cand[BRU_NUM].info.dueToViolation = 1'b1;
        cand[BRU_NUM].info.arch_pc        = i_viol_pc;
        cand[BRU_NUM].info.ldpc           = i_viol_ldpc;
        cand[BRU_NUM].info.stpc           = i_viol_stpc;
    end

    assign held_vld = (state_q == StPending);

    oldest_cand_select #(
        .NUM_CAND (NumCand)
    ) u_select (
        .held_vld_i (held_vld),
        .held_i     (held_q),
        .cand_vld_i (cand_vld),
        .cand_i     (cand),
        .sel_vld_o  (sel_vld),
        .sel_new_o  (sel_new),
        .sel_o      (sel)
    );

    // Trigger looks only at the entry held before this edge.
    always_comb begin
        retire_hit = 1'b0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (i_retire_vld[k] && (i_retire_robidx[k] == held_q.rob_idx)) begin
                retire_hit = 1'b1;
            end
        end
        head_hit = i_rob_head_vld && (i_rob_head_robidx == held_q.rob_idx);
        trigger  = held_vld && ((held_q.info.dueToBranch && retire_hit) ||
                                (held_q.info.dueToViolation && head_hit));
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        unique case (state_q)
            StIdle: begin
                if (!i_flush && sel_vld) begin
                    state_d = StPending;
                    held_d  = sel;
                end
            end
            StPending: begin
                // Squash outranks a same-cycle flush: the flushed op is younger.
                if (trigger) begin
                    state_d = StSquash;
                end else if (i_flush) begin
                    state_d = StIdle;
                end else if (sel_new) begin
                    held_d = sel;
                end
            end
            StSquash: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pending_d        = (state_d == StPending);
        pending_robidx_d = pending_d ? held_d.rob_idx : '0;
        squash_vld_d     = (state_d == StSquash);
        squash_info_d    = squash_vld_d ? held_d.info : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            held_q           <= '0;
            pending_q        <= 1'b0;
            pending_robidx_q <= '0;
            squash_vld_q     <= 1'b0;
            squash_info_q    <= '0;
        end else begin
            state_q          <= state_d;
            held_q           <= held_d;
            pending_q        <= pending_d;
            pending_robidx_q <= pending_robidx_d;
            squash_vld_q     <= squash_vld_d;
            squash_info_q    <= squash_info_d;
        end
    end

    assign o_pending        = pending_q;
    assign o_pending_robidx = pending_robidx_q;
    assign o_squash_vld     = squash_vld_q;
    assign o_squash_info    = squash_info_q;

endmodule

// File: tb/tb_squash_arbiter.sv
module tb_squash_arbiter;
    import squash_pkg::*;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [1:0]                       bwb_vld;
    branchwbInfo_t [1:0]              bwb_info;
    logic                             viol_vld;
    robIdx_t                          viol_robidx;
    logic [MEMDEP_FOLDPC_WIDTH-1:0]   viol_ldpc, viol_stpc;
    logic [XLEN-1:0]                  viol_pc;
    logic                             head_vld;
    robIdx_t                          head_robidx;
    logic [3:0]                       retire_vld;
    robIdx_t [3:0]                    retire_robidx;
    logic                             flush;
    logic                             o_pending;
    robIdx_t                          o_pending_robidx;
    logic                             o_squash_vld;
    squashInfo_t                      o_squash_info;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: absolute 7-bit ROB position, info and squash flag.
    bit          m_valid = 1'b0;
    int          m_age   = 0;
    squashInfo_t m_info  = '0;
    bit          m_sq    = 1'b0;
    squashInfo_t m_sq_info = '0;
    bit          exp_pending;
    int          exp_idx;
    bit          exp_sq;
    squashInfo_t exp_info;
    int          base = 0;

    squash_arbiter #(.BRU_NUM(2), .COMMIT_WIDTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_bwb_vld         (bwb_vld),
        .i_bwb_info        (bwb_info),
        .i_viol_vld        (viol_vld),
        .i_viol_robidx     (viol_robidx),
        .i_viol_ldpc       (viol_ldpc),
        .i_viol_stpc       (viol_stpc),
        .i_viol_pc         (viol_pc),
        .i_rob_head_vld    (head_vld),
        .i_rob_head_robidx (head_robidx),
        .i_retire_vld      (retire_vld),
        .i_retire_robidx   (retire_robidx),
        .i_flush           (flush),
        .o_pending         (o_pending),
        .o_pending_robidx  (o_pending_robidx),
        .o_squash_vld      (o_squash_vld),
        .o_squash_info     (o_squash_info)
    );

    always #5 clk = ~clk;

    function automatic robIdx_t to_rob(int a);
        robIdx_t r;
        r.flag = a[6];
        r.idx  = a[5:0];
        return r;
    endfunction

    function automatic int pos(robIdx_t r);
        return int'(r.flag) * 64 + int'(r.idx);
    endfunction

    // a is older than b when b lies 1..63 slots ahead of a on the 128-slot ring.
    function automatic bit older(int a, int b);
        int d;
        d = (b - a + 128) % 128;
        return (d >= 1) && (d <= 63);
    endfunction

    function automatic int rand_near();
        return (base + int'($urandom_range(0, 40))) % 128;
    endfunction

    task automatic model_step();
        bit          trig;
        bit          best_v;
        int          best_age;
        squashInfo_t best_info;
        squashInfo_t ci;
        if (rst) begin
            m_valid = 1'b0;
            m_sq    = 1'b0;
        end else if (m_sq) begin
            m_sq    = 1'b0;
            m_valid = 1'b0;
        end else begin
            trig = 1'b0;
            if (m_valid) begin
                if (m_info.dueToBranch) begin
                    for (int k = 0; k < 4; k++)
                        if (retire_vld[k] && pos(retire_robidx[k]) == m_age) trig = 1'b1;
                end else if (head_vld && pos(head_robidx) == m_age) begin
                    trig = 1'b1;
                end
            end
            if (trig) begin
                m_sq      = 1'b1;
                m_sq_info = m_info;
                m_valid   = 1'b0;
            end else if (flush) begin
                m_valid = 1'b0;
            end else begin
                best_v    = 1'b0;
                best_age  = 0;
                best_info = '0;
                for (int j = 0; j < 2; j++) begin
                    if (bwb_vld[j] && bwb_info[j].has_mispred) begin
                        ci              = '0;
                        ci.dueToBranch  = 1'b1;
                        ci.branch_taken = bwb_info[j].branch_taken;
                        ci.arch_pc      = bwb_info[j].branch_npc;
                        if (!best_v || older(pos(bwb_info[j].rob_idx), best_age)) begin
                            best_v    = 1'b1;
                            best_age  = pos(bwb_info[j].rob_idx);
                            best_info = ci;
                        end
                    end
                end
                if (viol_vld) begin
                    ci                = '0;
                    ci.dueToViolation = 1'b1;
                    ci.arch_pc        = viol_pc;
                    ci.ldpc           = viol_ldpc;
                    ci.stpc           = viol_stpc;
                    if (!best_v || older(pos(viol_robidx), best_age)) begin
                        best_v    = 1'b1;
                        best_age  = pos(viol_robidx);
                        best_info = ci;
                    end
                end
                if (best_v && (!m_valid || older(best_age, m_age))) begin
                    m_valid = 1'b1;
                    m_age   = best_age;
                    m_info  = best_info;
                end
            end
        end
        exp_pending = m_valid;
        exp_idx     = m_valid ? m_age : 0;
        exp_sq      = m_sq;
        exp_info    = m_sq ? m_sq_info : '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            n_cmp++;
            if (o_pending !== exp_pending || pos(o_pending_robidx) != exp_idx ||
                o_squash_vld !== exp_sq || o_squash_info !== exp_info) begin
                n_fail++;
                $display("FAIL model t=%0t: got pend=%0b idx=%0d sq=%0b info=%h, want pend=%0b idx=%0d sq=%0b info=%h",
                         $time, o_pending, pos(o_pending_robidx), o_squash_vld, o_squash_info,
                         exp_pending, exp_idx, exp_sq, exp_info);
            end
        end
    end

    task automatic lit(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        rst           = 1'b0;
        bwb_vld       = '0;
        bwb_info      = '0;
        viol_vld      = 1'b0;
        viol_robidx   = '0;
        viol_ldpc     = '0;
        viol_stpc     = '0;
        viol_pc       = '0;
        head_vld      = 1'b0;
        head_robidx   = '0;
        retire_vld    = '0;
        retire_robidx = '0;
        flush         = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic step();
        model_step();
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic bwb(int port, int a, logic [63:0] npc, bit taken);
        bwb_vld[port]                  = 1'b1;
        bwb_info[port].rob_idx         = to_rob(a);
        bwb_info[port].has_mispred     = 1'b1;
        bwb_info[port].branch_taken    = taken;
        bwb_info[port].branch_npc      = npc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        // Reset
        for (int i = 0; i < 3; i++) begin
            next(); rst = 1'b1; step();
        end
        lit("reset_pending", 64'(o_pending), 64'd0);
        lit("reset_squash", 64'(o_squash_vld), 64'd0);
        lit("reset_info", 64'(o_squash_info.arch_pc), 64'd0);

        // Single branch mispredict, retired on lane 2 three cycles later
        next(); bwb(0, 5, 64'h8000_1000, 1'b1); step();
        lit("br_pending", 64'(o_pending), 64'd1);
        lit("br_pending_idx", 64'(pos(o_pending_robidx)), 64'd5);
        next(); step();
        next(); step();
        next(); retire_vld[2] = 1'b1; retire_robidx[2] = to_rob(5); step();
        lit("br_squash_vld", 64'(o_squash_vld), 64'd1);
        lit("br_due_branch", 64'(o_squash_info.dueToBranch), 64'd1);
        lit("br_arch_pc", o_squash_info.arch_pc, 64'h8000_1000);
        next(); step();
        lit("br_single_pulse", 64'(o_squash_vld), 64'd0);

        // Two ports same cycle, then an older violation
        next(); bwb(0, 10, 64'h100, 1'b0); bwb(1, 7, 64'h200, 1'b1); step();
        lit("two_port_oldest", 64'(pos(o_pending_robidx)), 64'd7);
        next();
        viol_vld = 1'b1; viol_robidx = to_rob(3); viol_ldpc = 10'h155;
        viol_stpc = 10'h2AA; viol_pc = 64'h8000_2000;
        step();
        lit("viol_replace", 64'(pos(o_pending_robidx)), 64'd3);
        next(); head_vld = 1'b1; head_robidx = to_rob(3); step();
        lit("viol_squash", 64'(o_squash_vld), 64'd1);
        lit("viol_due", 64'(o_squash_info.dueToViolation), 64'd1);
        lit("viol_ldpc", 64'(o_squash_info.ldpc), 64'h155);
        lit("viol_stpc", 64'(o_squash_info.stpc), 64'h2AA);
        next(); step();

        // Wraparound: {1,1} is younger than {0,62}; {0,60} is older
        next(); bwb(0, 62, 64'h300, 1'b0); step();
        next(); bwb(1, 64 + 1, 64'h400, 1'b0); step();
        lit("wrap_keep", 64'(pos(o_pending_robidx)), 64'd62);
        next(); bwb(0, 60, 64'h500, 1'b0); step();
        lit("wrap_replace", 64'(pos(o_pending_robidx)), 64'd60);

        // Flush drops the candidate without a squash
        next(); flush = 1'b1; step();
        lit("flush_pending", 64'(o_pending), 64'd0);
        lit("flush_no_squash", 64'(o_squash_vld), 64'd0);

        // Flush and trigger together: squash wins; new wb during squash ignored
        next(); bwb(0, 20, 64'h600, 1'b1); step();
        next(); retire_vld[0] = 1'b1; retire_robidx[0] = to_rob(20); flush = 1'b1; step();
        lit("flush_trig_squash", 64'(o_squash_vld), 64'd1);
        lit("flush_trig_pc", o_squash_info.arch_pc, 64'h600);
        next(); bwb(0, 2, 64'h700, 1'b0); step();
        lit("squash_ignore_pend", 64'(o_pending), 64'd0);
        next(); step();
        lit("squash_ignore_idle", 64'(o_pending), 64'd0);

        // Reset mid-pending
        next(); bwb(1, 9, 64'h800, 1'b0); step();
        lit("rst_pre_pending", 64'(o_pending), 64'd1);
        next(); rst = 1'b1; step();
        lit("rst_pending", 64'(o_pending), 64'd0);
        lit("rst_idx", 64'(pos(o_pending_robidx)), 64'd0);
        next(); retire_vld[1] = 1'b1; retire_robidx[1] = to_rob(9); step();
        lit("rst_no_squash", 64'(o_squash_vld), 64'd0);

        // Randomized traffic over a drifting window that wraps the ring
        for (int c = 0; c < 4000; c++) begin
            next();
            base = (base + int'($urandom_range(0, 3))) % 128;
            for (int j = 0; j < 2; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bwb(j, rand_near(), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                    bwb_info[j].has_mispred = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 5) == 0) begin
                viol_vld    = 1'b1;
                viol_robidx = to_rob(rand_near());
                viol_ldpc   = 10'($urandom);
                viol_stpc   = 10'($urandom);
                viol_pc     = {$urandom, $urandom};
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    retire_vld[k]    = 1'b1;
                    retire_robidx[k] = ($urandom_range(0, 3) == 0 && m_valid) ?
                                       to_rob(m_age) : to_rob(rand_near());
                end
            end
            head_vld    = 1'($urandom_range(0, 1));
            head_robidx = ($urandom_range(0, 2) == 0 && m_valid) ? to_rob(m_age)
                                                                 : to_rob(rand_near());
            flush = ($urandom_range(0, 31) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end

        next(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
